uart_rx_cmd_parser: RTL
=======================

// Module: uart_rx_cmd_parser
// PURPOSE
//  Downstream of the UART receiver. Consumes its byte stream (rx_data, rx_data_rdy, frm_err).
//  Assembles 5-byte command frames: SYNC, ADDR, DATA_H, DATA_L, CHK.
//  Validated frames are presented as register-write commands on a valid/ready handshake
//  to the IC config register bank.
//  Checksum, framing, timeout and overrun errors are reported as 1-cycle pulses.
// PARAMETERS
//  SYNC_BYTE     8'hA5    frame start marker
//  TIMEOUT_CLKS  100_000  max inter-byte gap in clk_rx cycles inside a frame (2ms @ 50MHz); >=2
//  localparam TO_W = $clog2(TIMEOUT_CLKS)  timeout counter width
// PORTS
//  clk_rx       in   1   system clock
//  rst_clk_rx   in   1   reset, asynchronous assert, active-high
//  rx_data      in   8   received byte, valid when rx_data_rdy=1
//  rx_data_rdy  in   1   1-cycle strobe per received byte
//  frm_err      in   1   stop bit missing; sampled only with rx_data_rdy
//  cmd_addr     out  8   register address, stable while cmd_valid=1
//  cmd_data     out  16  {DATA_H,DATA_L}, stable while cmd_valid=1
//  cmd_valid    out  1   command pending
//  cmd_ready    in   1   consumer accepts; transfer when cmd_valid&cmd_ready
//  chk_err      out  1   pulse: checksum mismatch, frame dropped
//  to_err       out  1   pulse: inter-byte timeout, frame dropped
//  ovr_err      out  1   pulse: byte arrived while command pending, byte dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0, data/addr regs 0.
//  States and transitions (all taken only on rx_data_rdy unless noted):
//  - IDLE: byte==SYNC_BYTE & !frm_err -> ADDR. Any other byte is ignored, no error.
//  - ADDR: latch addr -> DATH. A SYNC value here is data, with no resync.
//  - DATH: latch data_h -> DATL.
//  - DATL: latch data_l -> CHK.
//  - CHK: if byte == addr^data_h^data_l -> HOLD, updating cmd_addr/cmd_data in the same edge.
//    On mismatch: chk_err=1 for 1 cycle -> IDLE.
//  - HOLD: cmd_valid=1. On cmd_valid&cmd_ready -> IDLE next cycle. cmd_ready is ignored in other states.
//  Latency: cmd_valid rises on the clock edge after the CHK byte's rx_data_rdy cycle.
//  frm_err=1 with rx_data_rdy in ADDR..CHK: byte discarded -> IDLE, no extra error pulse.
//  frm_err in IDLE: byte ignored.
//  Timeout: counter runs in ADDR..CHK and clears on every accepted byte and on leaving these states.
//  When it reaches TIMEOUT_CLKS-1 with no byte that cycle: to_err=1 for 1 cycle -> IDLE.
//  Timeout and rx_data_rdy in the same cycle: the byte wins; no timeout, counter cleared.
//  Any rx_data_rdy in HOLD, including the handshake cycle: byte dropped, ovr_err=1 for 1 cycle.
//  State is unchanged by this, and frm_err is irrelevant.
//  Reset mid-frame or mid-HOLD: immediate return to reset values; the pending command is lost.
//  Error pulses are registered, asserted the cycle after the causing event, and mutually exclusive.
// CONFIGURATION
//  UART_CMD_PARSER_STATS_EN defined: adds output err_cnt [15:0].
//  err_cnt increments on each chk_err, to_err or ovr_err pulse and saturates at 16'hFFFF.
//  It resets to 0 and is cleared by a 1-cycle pulse on added input err_cnt_clr (in, 1).
//  If clear and increment happen in the same cycle, the result is 0.
//  UART_CMD_PARSER_STATS_EN undefined: neither port exists, and the parser logic is identical.
// TESTING
//  1. Send A5 12 34 56 70 with cmd_ready=1 -> one cycle cmd_valid, cmd_addr=12, cmd_data=3456, no errors.
//  2. Send A5 12 34 56 71 -> chk_err 1 pulse, cmd_valid stays 0, next good frame accepted.
//  3. Send A5 12, then idle TIMEOUT_CLKS cycles -> to_err pulse. Then 34 56 70 ignored,
//     cmd_valid stays 0.
//  4. Send a good frame with cmd_ready=0, then byte 55 -> ovr_err pulse, cmd_addr/data unchanged.
//     Raise cmd_ready -> handshake, then IDLE.
//  5. Send A5 12 with frm_err=1 on 12 -> IDLE. A following A5 12 34 56 70 yields a command.
//  6. Assert rst_clk_rx during DATL and in HOLD -> all outputs 0 immediately. Under STATS_EN:
//     cnt saturation at FFFF and clr-vs-inc priority checked.

Source files
------------

// File: rtl/uart_rx_cmd_parser.sv
// Assembles SYNC/ADDR/DATA_H/DATA_L/CHK frames from the UART byte stream into register-write commands.
// Optional error statistics counter: define UART_CMD_PARSER_STATS_EN.
module uart_rx_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100_000
) (
  input  logic        clk_rx,
  input  logic        rst_clk_rx,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  input  logic        frm_err,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        chk_err,
  output logic        to_err,
  output logic        ovr_err
`ifdef UART_CMD_PARSER_STATS_EN
  ,
  input  logic        err_cnt_clr,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATH,
    S_DATL,
    S_CHK,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_addr;
  logic [7:0]      r_dh;
  logic [7:0]      r_dl;

  logic       w_in_frame;
  logic       w_byte_ok;
  logic       w_to_hit;
  logic       w_abort;
  logic [7:0] w_chk;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATH) ||
                      (r_state == S_DATL) || (r_state == S_CHK);
  assign w_byte_ok  = rx_data_rdy && !frm_err;
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign w_to_hit   = w_in_frame && !rx_data_rdy && (r_to_cnt == TO_LAST);
  assign w_abort    = w_in_frame && ((rx_data_rdy && frm_err) || w_to_hit);
  assign w_chk      = r_addr ^ r_dh ^ r_dl;

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_addr    <= '0;
      r_dh      <= '0;
      r_dl      <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      chk_err   <= 1'b0;
      to_err    <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      chk_err <= 1'b0;
      to_err  <= w_to_hit;
      ovr_err <= 1'b0;

      if (!w_in_frame || rx_data_rdy || w_to_hit) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_abort) begin
        r_state <= S_IDLE;
      end

      case (r_state)
        S_IDLE: begin
          if (w_byte_ok && (rx_data == SYNC_BYTE)) begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_byte_ok) begin
            r_addr  <= rx_data;
            r_state <= S_DATH;
          end
        end
        S_DATH: begin
          if (w_byte_ok) begin
            r_dh    <= rx_data;
            r_state <= S_DATL;
          end
        end
        S_DATL: begin
          if (w_byte_ok) begin
            r_dl    <= rx_data;
            r_state <= S_CHK;
          end
        end
        S_CHK: begin
          if (w_byte_ok) begin
            if (rx_data == w_chk) begin
              cmd_addr  <= r_addr;
              cmd_data  <= {r_dh, r_dl};
              cmd_valid <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              chk_err <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (rx_data_rdy) begin
            ovr_err <= 1'b1;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_CMD_PARSER_STATS_EN
  logic w_err_any;

  assign w_err_any = chk_err || to_err || ovr_err;

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (w_err_any && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
